cam_capture_gray: RTL
=====================

Name: cam_capture_gray

Overview:
- Capture stage on the camera side of the frame buffer.
- Samples the camera's 8-bit YUV422 byte stream framed by VSYNC/HREF and extracts the luma byte of each pixel.
- Writes that luma as a 4-bit grey value into the frame-buffer write port at address y*H_ACTIVE+x.
- The VGA display stage later reads this buffer by (x,y) and drives the same 4-bit value onto R, G and B.

Parameters:
- H_ACTIVE, 640, pixels per line written to the buffer.
- V_ACTIVE, 480, lines per frame written to the buffer.
- ADDR_W, 19, frame-buffer address width; must hold H_ACTIVE*V_ACTIVE-1.
- Y_FIRST, 1, 1 = byte order Y,U,Y,V (luma is the even byte); 0 = U,Y,V,Y (luma is the odd byte).

Ports:
- pixel_clk  in  1  camera PCLK; the only clock.
- reset  in  1  synchronous, active-high.
- capture_en  in  1  sampled at frame start; 0 freezes the buffer contents.
- cam_vsync  in  1  camera VSYNC, high between frames.
- cam_href  in  1  camera HREF, high while a line's bytes are valid.
- cam_d  in  8  camera data byte.
- wr_en  out  1  frame-buffer write strobe, one cycle per pixel.
- wr_addr  out  ADDR_W  frame-buffer write address.
- wr_data  out  4  grey value, luma[7:4].
- outX  out  10  current pixel column counter.
- outY  out  9  current line counter.
- frame_done  out  1  one-cycle pulse at the end of each captured frame.

Behaviour:
- Clocking and reset:
  - One clock, pixel_clk.
  - Reset is synchronous and active-high.
- Input registering:
  - cam_vsync, cam_href and cam_d are registered once (stage 1).
  - All control decisions use the registered copies plus a 1-cycle-delayed copy of vsync/href for edge detection.
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0, outX=0, outY=0, frame_done=0.
  - Byte phase = 0; state = SYNC.
  - Reset mid-frame discards the partial frame: no further writes occur until the next full frame start.
- States:
  - SYNC: after reset, waits for a registered vsync falling edge (guarantees a whole frame). On that edge: CAPTURE if capture_en=1, else SKIP.
  - CAPTURE: writes pixels. On registered vsync rising edge: pulse frame_done for 1 cycle, then go to SYNC_WAIT.
  - SKIP: no writes and no frame_done. On vsync rising edge: go to SYNC_WAIT.
  - SYNC_WAIT: on vsync falling edge: CAPTURE if capture_en=1, else SKIP.
  - outX and outY are zeroed on every vsync falling edge.
- Byte pairing:
  - While registered href=1, the byte phase toggles every cycle. It is forced to 0 whenever href=0.
  - The luma byte is the phase-0 byte when Y_FIRST=1, or the phase-1 byte when Y_FIRST=0; it is held in a register.
  - The pixel completes on the phase-1 byte.
- Write timing:
  - When a pixel completes in CAPTURE with outX<H_ACTIVE and outY<V_ACTIVE:
    - wr_en=1 for exactly one cycle.
    - wr_addr = outY*H_ACTIVE+outX, computed with an ADDR_W-bit multiply-add. A running-accumulator implementation is allowed if the result is identical.
    - wr_data = luma[7:4].
  - Then outX increments.
- Latency: the phase-1 byte is on cam_d at edge k; wr_en, wr_addr and wr_data are valid after edge k+2.
- Line end:
  - On registered href falling edge: outX=0 and outY increments (saturating at 511).
  - An odd trailing byte is dropped.
- Boundary handling:
  - Pixels with outX>=H_ACTIVE and lines with outY>=V_ACTIVE produce no write; outX saturates at 1023.
  - A vsync rise while href=1 ends the frame. The partial pixel is dropped and frame_done still pulses.
  - A capture_en change mid-frame has no effect until the next frame start.
  - wr_addr never exceeds H_ACTIVE*V_ACTIVE-1.

Optional Feature:
- Macro: CAPTURE_ERR_EN.
- When defined:
  - Extra output line_err (1 bit), reset 0.
  - On each registered href falling edge in CAPTURE, if the completed pixel count for that line != H_ACTIVE, line_err is set sticky. It clears on the next vsync falling edge that starts a CAPTURE frame.
  - A short or long line does not alter writes.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- H_ACTIVE=4, V_ACTIVE=3, Y_FIRST=1, capture_en=1. Reset, vsync pulse, then 3 lines of bytes 0xA0,0x11,0xB0,0x22,0xC0,0x33,0xD0,0x44. Required: 12 writes, addr 0..11, data A,B,C,D per line; one frame_done after the vsync rise; each wr_en 2 cycles after its odd byte.
- Same stream with Y_FIRST=0. Required: data 1,2,3,4 per line.
- Line of 6 pixels with H_ACTIVE=4. Required: only addr 0..3 written for that line; next line starts at addr 4. With CAPTURE_ERR_EN, line_err=1.
- capture_en=0 at frame start, raised mid-frame. Required: zero writes and no frame_done that frame; the next frame captures normally.
- Reset asserted during line 1 of a frame, then released. Required: all outputs 0; no writes until after the next vsync falling edge; the following frame's writes start at addr 0.
- Stream 5 lines with V_ACTIVE=3, vsync rising while href=1 mid-line. Required: no write with addr>11; the partial pixel is dropped; frame_done pulses exactly once.

Source files
------------

// File: rtl/cam_capture_gray.sv
// cam_capture_gray: camera-side capture stage; YUV422 bytes -> 4-bit grey
// frame-buffer writes at y*H_ACTIVE+x, framed by VSYNC/HREF.
// Ports: pixel_clk, reset (sync, active-high), capture_en, cam_vsync,
//   cam_href, cam_d[7:0] in; wr_en, wr_addr, wr_data[3:0], outX[9:0],
//   outY[8:0], frame_done out; line_err out when CAPTURE_ERR_EN is defined.
// Optional macro: CAPTURE_ERR_EN (sticky wrong-line-length flag).
module cam_capture_gray #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19,
    parameter bit Y_FIRST  = 1'b1
) (
    input  logic              pixel_clk,
    input  logic              reset,
    input  logic              capture_en,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_d,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        wr_data,
    output logic [9:0]        outX,
    output logic [8:0]        outY,
    output logic              frame_done
`ifdef CAPTURE_ERR_EN
    ,
    output logic              line_err
`endif
);

    typedef enum logic [1:0] {
        SYNC,
        CAPTURE,
        SKIP,
        SYNC_WAIT
    } state_t;

    localparam logic [10:0]       H_LIM = 11'(H_ACTIVE);
    localparam logic [9:0]        V_LIM = 10'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] H_MUL = ADDR_W'(H_ACTIVE);

    state_t      state;
    logic        vs_r, hr_r, vs_d, hr_d;
    logic [3:0]  d_hi;
    logic        phase;
    logic [3:0]  luma;
    logic        pix_vld;
    logic [3:0]  pix_luma;

    // Only the high nibble reaches the grey output.
    logic unused_lo;
    assign unused_lo = ^cam_d[3:0];

    logic vs_fall, vs_rise, hr_fall;
    assign vs_fall = vs_d & ~vs_r;
    assign vs_rise = ~vs_d & vs_r;
    assign hr_fall = hr_d & ~hr_r;

    logic              x_ok, y_ok;
    logic [ADDR_W-1:0] addr_calc;
    assign x_ok      = {1'b0, outX} < H_LIM;
    assign y_ok      = {1'b0, outY} < V_LIM;
    assign addr_calc = ADDR_W'(outY) * H_MUL + ADDR_W'(outX);

`ifdef CAPTURE_ERR_EN
    // Pixels completed on this line, counting one finishing this cycle.
    logic [10:0] line_cnt;
    assign line_cnt = {1'b0, outX} + 11'(pix_vld);
`endif

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state      <= SYNC;
            vs_r       <= 1'b0;
            hr_r       <= 1'b0;
            vs_d       <= 1'b0;
            hr_d       <= 1'b0;
            d_hi       <= '0;
            phase      <= 1'b0;
            luma       <= '0;
            pix_vld    <= 1'b0;
            pix_luma   <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            outX       <= '0;
            outY       <= '0;
            frame_done <= 1'b0;
`ifdef CAPTURE_ERR_EN
            line_err   <= 1'b0;
`endif
        end else begin
            vs_r       <= cam_vsync;
            hr_r       <= cam_href;
            d_hi       <= cam_d[7:4];
            vs_d       <= vs_r;
            hr_d       <= hr_r;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;

            // Byte pairing: phase restarts at 0 on every line.
            phase   <= hr_r & ~phase;
            pix_vld <= hr_r & phase;
            if (hr_r && !phase)
                luma <= d_hi;
            pix_luma <= Y_FIRST ? luma : d_hi;

            if (state == CAPTURE) begin
                if (pix_vld) begin
                    if (x_ok && y_ok) begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr_calc;
                        wr_data <= pix_luma;
                    end
                    if (outX != 10'h3ff)
                        outX <= outX + 10'd1;
                end
                // Line end wins over the increment of a pixel finishing now.
                if (hr_fall) begin
                    outX <= '0;
                    if (outY != 9'h1ff)
                        outY <= outY + 9'd1;
`ifdef CAPTURE_ERR_EN
                    if (line_cnt != H_LIM)
                        line_err <= 1'b1;
`endif
                end
            end

            unique case (state)
                SYNC, SYNC_WAIT: begin
                    if (vs_fall) begin
                        state <= capture_en ? CAPTURE : SKIP;
`ifdef CAPTURE_ERR_EN
                        if (capture_en)
                            line_err <= 1'b0;
`endif
                    end
                end
                CAPTURE: begin
                    if (vs_rise) begin
                        frame_done <= 1'b1;
                        state      <= SYNC_WAIT;
                    end
                end
                SKIP: begin
                    if (vs_rise)
                        state <= SYNC_WAIT;
                end
                default: state <= SYNC;
            endcase

            if (vs_fall) begin
                outX <= '0;
                outY <= '0;
            end
        end
    end

endmodule
